// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 serial-to-parallel receiver with a 2-flop synchronizer and falling-edge start detect.
// Each good frame updates dataout with a one-cycle data_valid; a bad stop bit gives a one-cycle frame_err.
module uart_receiver #(
    parameter int clk_freq = 1000,
    parameter int baudrate = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] dataout,
    output logic       data_valid,
    output logic       frame_err,
    output logic       busy
);
    localparam int baud_cnt = clk_freq / baudrate;
    localparam int cw = $clog2(baud_cnt);
    localparam logic [cw-1:0] half_last = cw'(baud_cnt / 2 - 1);
    localparam logic [cw-1:0] bit_last = cw'(baud_cnt - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state, state_n;
    logic [cw-1:0] cnt, cnt_n;
    logic [2:0]    bit_idx, bit_idx_n;
    logic [7:0]    shift_reg, shift_n;
    logic [7:0]    dataout_n;
    logic          data_valid_n, frame_err_n;
    logic          rx_m, rx_s, rx_d;
    logic          start_det;

    // Preset to 1 so that releasing reset on an idle line never looks like a start edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
            rx_d <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
            rx_d <= rx_s;
        end
    end

    assign start_det = rx_d & ~rx_s;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shift_reg  <= '0;
            dataout    <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            bit_idx    <= bit_idx_n;
            shift_reg  <= shift_n;
            dataout    <= dataout_n;
            data_valid <= data_valid_n;
            frame_err  <= frame_err_n;
        end
    end

    always_comb begin
        state_n      = state;
        cnt_n        = cnt + 1'b1;
        bit_idx_n    = bit_idx;
        shift_n      = shift_reg;
        dataout_n    = dataout;
        data_valid_n = 1'b0;
        frame_err_n  = 1'b0;
        case (state)
            IDLE: begin
                cnt_n   = '0;
                state_n = start_det ? START : IDLE;
            end
            START: if (cnt == half_last) begin
                cnt_n     = '0;
                bit_idx_n = '0;
                state_n   = rx_s ? IDLE : DATA;
            end
            DATA: if (cnt == bit_last) begin
                cnt_n            = '0;
                shift_n[bit_idx] = rx_s;
                bit_idx_n        = bit_idx + 3'd1;
                state_n          = (bit_idx == 3'd7) ? STOP : DATA;
            end
            STOP: if (cnt == bit_last) begin
                cnt_n        = '0;
                state_n      = IDLE;
                dataout_n    = rx_s ? shift_reg : dataout;
                data_valid_n = rx_s;
                frame_err_n  = ~rx_s;
            end
            default: state_n = IDLE;
        endcase
    end

    assign busy = (state != IDLE);
endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: directed frame table plus hand-written glitch, back-to-back, held-low and
// mid-frame reset sequences against the 8N1 receiver at default timing (100 clk per bit).
module tb_uart_receiver;
    localparam int bit_clks = 100;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] dataout;
    logic       data_valid, frame_err, busy;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int dv_cnt = 0, fe_cnt = 0, busy_cnt = 0, anomalies = 0;
    int last_dv_cyc = 0, prev_dv_cyc = 0, start_cyc = 0;
    logic [7:0] last_dout = '0, prev_dout = '0;
    logic prev_pulse = 1'b0;

    uart_receiver dut (
        .clk(clk), .rst(rst), .rx(rx), .dataout(dataout),
        .data_valid(data_valid), .frame_err(frame_err), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst) begin
            if (data_valid) begin
                dv_cnt++;
                prev_dv_cyc = last_dv_cyc;
                last_dv_cyc = cyc;
                prev_dout = last_dout;
                last_dout = dataout;
            end
            if (frame_err) fe_cnt++;
            if (busy) busy_cnt++;
            if (data_valid && frame_err) anomalies++;
            if ((data_valid || frame_err) && prev_pulse) anomalies++;
            prev_pulse = data_valid || frame_err;
        end else prev_pulse = 1'b0;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        logic [9:0] f;
        f = {stop, d, 1'b0};
        start_cyc = cyc;
        for (int i = 0; i < 10; i++) begin
            rx = f[i];
            idle(bit_clks);
        end
        rx = 1'b1;
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic [7:0] exp_dout;
        int         exp_dv;
        int         exp_fe;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int dv0, fe0, b0;
        vecs[0] = '{8'h55, 1'b1, 8'h55, 1, 0};
        vecs[1] = '{8'hA3, 1'b0, 8'h55, 0, 1};
        vecs[2] = '{8'hA3, 1'b1, 8'hA3, 1, 0};
        vecs[3] = '{8'h00, 1'b1, 8'h00, 1, 0};
        vecs[4] = '{8'hFF, 1'b1, 8'hFF, 1, 0};
        vecs[5] = '{8'h80, 1'b1, 8'h80, 1, 0};
        vecs[6] = '{8'h01, 1'b0, 8'h80, 0, 1};

        #1;
        check("reset_dataout", {24'd0, dataout}, 32'h00);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_pulses", {30'd0, data_valid, frame_err}, 32'd0);
        idle(3);
        rst = 1'b1;
        idle(500);
        check("idle_dv", dv_cnt, 0);
        check("idle_fe", fe_cnt, 0);
        check("idle_busy", busy_cnt, 0);
        check("idle_dataout", {24'd0, dataout}, 32'h00);

        for (int i = 0; i < 7; i++) begin
            dv0 = dv_cnt;
            fe0 = fe_cnt;
            send_frame(vecs[i].data, vecs[i].stop);
            idle(50);
            check($sformatf("vec%0d_dv", i), dv_cnt - dv0, vecs[i].exp_dv);
            check($sformatf("vec%0d_fe", i), fe_cnt - fe0, vecs[i].exp_fe);
            check($sformatf("vec%0d_dataout", i), {24'd0, dataout}, {24'd0, vecs[i].exp_dout});
            check($sformatf("vec%0d_busy", i), {31'd0, busy}, 32'd0);
            if (vecs[i].exp_dv == 1)
                check($sformatf("vec%0d_latency_ok", i),
                      {31'd0, (last_dv_cyc - start_cyc >= 950) && (last_dv_cyc - start_cyc <= 956)}, 32'd1);
        end

        dv0 = dv_cnt; fe0 = fe_cnt; b0 = busy_cnt;
        rx = 1'b0;
        idle(20);
        rx = 1'b1;
        idle(100);
        check("glitch_busy_seen", {31'd0, (busy_cnt - b0 > 0) && (busy_cnt - b0 < 100)}, 32'd1);
        check("glitch_busy_end", {31'd0, busy}, 32'd0);
        check("glitch_dv", dv_cnt - dv0, 0);
        check("glitch_fe", fe_cnt - fe0, 0);

        dv0 = dv_cnt; fe0 = fe_cnt;
        send_frame(8'hA3, 1'b1);
        send_frame(8'h0F, 1'b1);
        idle(50);
        check("b2b_dv", dv_cnt - dv0, 2);
        check("b2b_first", {24'd0, prev_dout}, 32'hA3);
        check("b2b_second", {24'd0, last_dout}, 32'h0F);
        check("b2b_spacing_ok",
              {31'd0, (last_dv_cyc - prev_dv_cyc >= 999) && (last_dv_cyc - prev_dv_cyc <= 1001)}, 32'd1);

        dv0 = dv_cnt; fe0 = fe_cnt;
        rx = 1'b0;
        idle(1500);
        check("held_low_fe", fe_cnt - fe0, 1);
        check("held_low_dv", dv_cnt - dv0, 0);
        check("held_low_busy", {31'd0, busy}, 32'd0);
        check("held_low_dataout", {24'd0, dataout}, 32'h0F);
        rx = 1'b1;
        idle(100);

        rx = 1'b0;
        idle(450);
        check("midframe_busy", {31'd0, busy}, 32'd1);
        rst = 1'b0;
        #1;
        check("midreset_dataout", {24'd0, dataout}, 32'h00);
        check("midreset_busy", {31'd0, busy}, 32'd0);
        check("midreset_pulses", {30'd0, data_valid, frame_err}, 32'd0);
        rx = 1'b1;
        idle(3);
        rst = 1'b1;
        idle(200);
        dv0 = dv_cnt; fe0 = fe_cnt;
        send_frame(8'h3C, 1'b1);
        idle(50);
        check("after_reset_dv", dv_cnt - dv0, 1);
        check("after_reset_fe", fe_cnt - fe0, 0);
        check("after_reset_dataout", {24'd0, dataout}, 32'h3C);

        check("pulse_anomalies", anomalies, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
